// File: rtl/count_scheduler.sv
// count_scheduler: round-robin controller that lends one synchronous up-counter
// to NREQ requesters. The winner's terminal value is latched at grant. The
// counter then steps 0..target, and a one-cycle done pulse closes the run.
//
// Ports:
//   clk    - clock, all state changes on the rising edge
//   rst_n  - asynchronous active-low reset
//   req    - per-requester request level, held until done (drop to abort)
//   len    - packed terminal counts, slice i = len[i*WIDTH +: WIDTH]
//   gnt    - one-hot grant, zero when idle (registered)
//   busy   - high whenever the scheduler is not idle (registered)
//   count  - current counter value (registered)
//   done   - one-hot single-cycle completion pulse (registered)
module count_scheduler #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] len,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic [WIDTH-1:0]      count,
    output logic [NREQ-1:0]       done
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [PTR_W-1:0] LAST_RST = PTR_W'(NREQ - 1);

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic [PTR_W-1:0] last;
    logic [PTR_W-1:0] last_nx;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] target_nx;
    logic [WIDTH-1:0] count_nx;
    logic [NREQ-1:0]  gnt_nx;
    logic [NREQ-1:0]  done_nx;
    logic             busy_nx;

    logic [WIDTH-1:0] len_arr [NREQ];
    logic [PTR_W-1:0] win_idx;
    logic             win_valid;

    // Unpack the flat len bus into one terminal value per requester.
    for (genvar i = 0; i < NREQ; i++) begin : g_len
        assign len_arr[i] = len[i*WIDTH +: WIDTH];
    end

    // Round-robin pick: scan from last+1 upward with wrap. Scanning the
    // offsets from farthest to nearest lets the nearest hit overwrite, so
    // the first requester after the pointer wins.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req[PTR_W'((int'(last) + k) % NREQ)]) begin
                win_valid = 1'b1;
                win_idx   = PTR_W'((int'(last) + k) % NREQ);
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nx  = state;
        last_nx   = last;
        target_nx = target;
        count_nx  = count;
        gnt_nx    = gnt;
        done_nx   = '0;
        busy_nx   = busy;

        case (state)
            ST_IDLE: begin
                if (win_valid) begin
                    state_nx  = ST_RUN;
                    last_nx   = win_idx;
                    target_nx = len_arr[win_idx];
                    count_nx  = '0;
                    gnt_nx    = NREQ'(1) << win_idx;
                    busy_nx   = 1'b1;
                end
            end

            ST_RUN: begin
                // last always names the current grantee while running.
                if (!req[last]) begin
                    state_nx = ST_IDLE;
                    gnt_nx   = '0;
                    busy_nx  = 1'b0;
                end else if (count == target) begin
                    state_nx = ST_DONE;
                    done_nx  = gnt;
                end else begin
                    count_nx = count + WIDTH'(1);
                end
            end

            ST_DONE: begin
                state_nx = ST_IDLE;
                gnt_nx   = '0;
                busy_nx  = 1'b0;
            end

            default: begin
                state_nx = ST_IDLE;
                gnt_nx   = '0;
                busy_nx  = 1'b0;
            end
        endcase
    end

    // State, pointer, target and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            last   <= LAST_RST;
            target <= '0;
            count  <= '0;
            gnt    <= '0;
            done   <= '0;
            busy   <= 1'b0;
        end else begin
            state  <= state_nx;
            last   <= last_nx;
            target <= target_nx;
            count  <= count_nx;
            gnt    <= gnt_nx;
            done   <= done_nx;
            busy   <= busy_nx;
        end
    end

endmodule
